// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch sequencer
package cpu_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EX0   = 2'd1,
        S_EX1   = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_JMP  = 2'b10;
    localparam logic [1:0] PS_BR   = 2'b11;

endpackage

// File: rtl/cpu_pc_next.sv
// rtl/cpu_pc_next.sv - combinational next-PC selection from the decoder PS code
module cpu_pc_next
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = 16
) (
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [1:0]          ps_i,
    input  logic [PC_WIDTH-1:0] jump_addr_i,
    input  logic [7:0]          br_offset_i,
    output logic [PC_WIDTH-1:0] pc_next_o
);

    logic [PC_WIDTH-1:0] offset_ext;

    // Sized cast of a signed value sign-extends; sums wrap silently at PC_WIDTH.
    assign offset_ext = PC_WIDTH'($signed(br_offset_i));

    always_comb begin
        pc_next_o = pc_i;
        case (ps_i)
            PS_HOLD: pc_next_o = pc_i;
            PS_INC:  pc_next_o = pc_i + PC_WIDTH'(1);
            PS_JMP:  pc_next_o = jump_addr_i;
            PS_BR:   pc_next_o = pc_i + offset_ext;
            default: pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/cpu_fetch_sequencer.sv
// rtl/cpu_fetch_sequencer.sv - PC/IR owner: fetch handshake, execute phases, fetch timeout
module cpu_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                PC_WIDTH      = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                FETCH_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          PS,
    input  logic                IR_L,
    input  logic                NS,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic [7:0]          br_offset,
    input  logic [INSTR_W-1:0]  imem_data,
    input  logic                imem_ack,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic [PC_WIDTH-1:0] PC,
    output logic [INSTR_W-1:0]  IR,
    output logic                State,
    output logic                fetch_err
);

    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic                err_q, err_d;
    logic                req_c;
    logic [PC_WIDTH-1:0] pc_sel;

    cpu_pc_next #(.PC_WIDTH(PC_WIDTH)) u_pc_next (
        .pc_i        (pc_q),
        .ps_i        (PS),
        .jump_addr_i (jump_addr),
        .br_offset_i (br_offset),
        .pc_next_o   (pc_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        err_d   = err_q;
        req_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    wait_d  = '0;
                    state_d = S_EX0;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            // NS takes priority: PS/IR_L are meaningless until the second cycle.
            S_EX0: begin
                if (NS) begin
                    state_d = S_EX1;
                end else if (IR_L) begin
                    pc_d    = pc_sel;
                    state_d = S_FETCH;
                end
            end
            S_EX1: begin
                if (IR_L) begin
                    pc_d    = pc_sel;
                    state_d = S_FETCH;
                end
            end
            S_ERR: begin
                err_d = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign imem_req  = req_c & rst_n;
    assign imem_addr = pc_q;
    assign PC        = pc_q;
    assign IR        = ir_q;
    assign State     = (state_q == S_EX1);
    assign fetch_err = err_q;

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// tb/tb_cpu_fetch_sequencer.sv - scoreboard bench for cpu_fetch_sequencer
module tb_cpu_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  PS;
    logic        IR_L;
    logic        NS;
    logic [15:0] jump_addr;
    logic [7:0]  br_offset;
    logic [15:0] imem_data;
    logic        imem_ack;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] PC;
    logic [15:0] IR;
    logic        State;
    logic        fetch_err;

    int n_checks = 0;
    int n_err    = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    cpu_fetch_sequencer #(
        .PC_WIDTH      (16),
        .RESET_PC      (16'h0000),
        .FETCH_TIMEOUT (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PS        (PS),
        .IR_L      (IR_L),
        .NS        (NS),
        .jump_addr (jump_addr),
        .br_offset (br_offset),
        .imem_data (imem_data),
        .imem_ack  (imem_ack),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .PC        (PC),
        .IR        (IR),
        .State     (State),
        .fetch_err (fetch_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Pushes the expected fetch address and acks for one cycle.
    task automatic fetch(input logic [15:0] addr, input logic [15:0] data);
        exp_q.push_back(addr);
        imem_ack  = 1'b1;
        imem_data = data;
        tick();
        imem_ack  = 1'b0;
    endtask

    // Monitor: every accepted handshake is compared against the scoreboard.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && imem_req === 1'b1 && imem_ack === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL fetch_addr: unexpected fetch at %h, expected none", imem_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (imem_addr !== e) begin
                        n_err++;
                        $display("FAIL fetch_addr: got %h expected %h", imem_addr, e);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; PS = 2'b00; IR_L = 1'b0; NS = 1'b0;
        jump_addr = '0; br_offset = '0; imem_data = '0; imem_ack = 1'b0;
        tick(); tick();
        check("rst_pc", PC, 16'h0000);
        check("rst_ir", IR, 16'h0000);
        check("rst_state", State, 1'b0);
        check("rst_req", imem_req, 1'b0);
        check("rst_err", fetch_err, 1'b0);

        rst_n = 1'b1;
        tick();
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 16'h0000);
        fetch(16'h0000, 16'hA123);
        check("first_ir", IR, 16'hA123);
        check("first_pc", PC, 16'h0001);
        check("first_state", State, 1'b0);
        check("ex0_req", imem_req, 1'b0);

        tick();
        check("stall_pc", PC, 16'h0001);
        check("stall_state", State, 1'b0);
        imem_ack = 1'b1; imem_data = 16'hFFFF;
        tick();
        imem_ack = 1'b0;
        check("ack_ignored_ir", IR, 16'hA123);

        IR_L = 1'b1; PS = 2'b01;
        tick();
        IR_L = 1'b0; PS = 2'b00;
        check("inc_pc", PC, 16'h0002);
        check("inc_addr", imem_addr, 16'h0002);
        check("inc_req", imem_req, 1'b1);
        fetch(16'h0002, 16'h1234);
        check("zw_ir", IR, 16'h1234);
        check("zw_pc", PC, 16'h0003);

        NS = 1'b1; IR_L = 1'b1; PS = 2'b10; jump_addr = 16'h0040;
        tick();
        NS = 1'b0;
        check("ex1_state", State, 1'b1);
        check("ns_prio_pc", PC, 16'h0003);
        check("ex1_ir", IR, 16'h1234);
        tick();
        IR_L = 1'b0;
        check("jmp_pc", PC, 16'h0040);
        check("jmp_addr", imem_addr, 16'h0040);
        check("jmp_state", State, 1'b0);
        fetch(16'h0040, 16'h5555);
        check("jmp_fetch_pc", PC, 16'h0041);

        IR_L = 1'b1; PS = 2'b00;
        tick();
        IR_L = 1'b0;
        check("hold_pc", PC, 16'h0041);
        fetch(16'h0041, 16'h0BEE);

        IR_L = 1'b1; PS = 2'b10; jump_addr = 16'h0000;
        tick();
        IR_L = 1'b0;
        fetch(16'h0000, 16'h7777);
        check("pre_br_pc", PC, 16'h0001);

        IR_L = 1'b1; PS = 2'b11; br_offset = 8'hFE;
        tick();
        IR_L = 1'b0;
        check("br_back_pc", PC, 16'hFFFF);
        fetch(16'hFFFF, 16'h1111);
        check("wrap_pc", PC, 16'h0000);
        check("wrap_ir", IR, 16'h1111);

        IR_L = 1'b1; PS = 2'b11; br_offset = 8'h7F;
        tick();
        IR_L = 1'b0;
        check("br_fwd_pc", PC, 16'h007F);
        fetch(16'h007F, 16'h2222);

        NS = 1'b1;
        tick();
        NS = 1'b0;
        check("pre_rst_state", State, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_pc", PC, 16'h0000);
        check("async_ir", IR, 16'h0000);
        check("async_state", State, 1'b0);
        check("async_req", imem_req, 1'b0);
        tick();
        rst_n = 1'b1;

        tick();
        check("to1_err", fetch_err, 1'b0);
        check("to1_req", imem_req, 1'b1);
        tick();
        check("to2_err", fetch_err, 1'b0);
        tick();
        check("to3_err", fetch_err, 1'b1);
        check("to3_req", imem_req, 1'b0);
        imem_ack = 1'b1; imem_data = 16'hABCD;
        tick(); tick();
        imem_ack = 1'b0;
        check("err_ir", IR, 16'h0000);
        check("err_pc", PC, 16'h0000);
        check("err_sticky", fetch_err, 1'b1);

        rst_n = 1'b0;
        tick();
        check("clr_err", fetch_err, 1'b0);
        rst_n = 1'b1;
        tick();
        check("clr_req", imem_req, 1'b1);
        check("clr_err2", fetch_err, 1'b0);

        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
